// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode, instruction-code and width constants for the decode stage
package decode_stage_pkg;
  localparam int ISIZE = 32;
  localparam int ASIZE = 5;
  localparam int DSIZE = 32;
  localparam int CODE_BITS = 6;
  localparam logic [6:0] RTYPE_OPC = 7'b0110011;
  localparam logic [6:0] ITYPE_OPC = 7'b0010011;
  localparam logic [6:0] LOAD_OPC = 7'b0000011;
  localparam logic [6:0] STORE_OPC = 7'b0100011;
  localparam logic [6:0] CONBRANCH_OPC = 7'b1100011;
  localparam logic [6:0] JAL_OPC = 7'b1101111;
  localparam logic [6:0] JR_OPC = 7'b1100111;
  localparam logic [6:0] LUI_OPC = 7'b0110111;
  localparam logic [6:0] AUIPC_OPC = 7'b0010111;
  localparam logic [CODE_BITS-1:0] C_NOP = 6'd0;
  localparam logic [CODE_BITS-1:0] C_ADD = 6'd1;
  localparam logic [CODE_BITS-1:0] C_SUB = 6'd2;
  localparam logic [CODE_BITS-1:0] C_SLL = 6'd3;
  localparam logic [CODE_BITS-1:0] C_SLT = 6'd4;
  localparam logic [CODE_BITS-1:0] C_SLTU = 6'd5;
  localparam logic [CODE_BITS-1:0] C_XOR = 6'd6;
  localparam logic [CODE_BITS-1:0] C_SRL = 6'd7;
  localparam logic [CODE_BITS-1:0] C_SRA = 6'd8;
  localparam logic [CODE_BITS-1:0] C_OR = 6'd9;
  localparam logic [CODE_BITS-1:0] C_AND = 6'd10;
  localparam logic [CODE_BITS-1:0] C_ADDI = 6'd11;
  localparam logic [CODE_BITS-1:0] C_SLTI = 6'd12;
  localparam logic [CODE_BITS-1:0] C_SLTIU = 6'd13;
  localparam logic [CODE_BITS-1:0] C_XORI = 6'd14;
  localparam logic [CODE_BITS-1:0] C_ORI = 6'd15;
  localparam logic [CODE_BITS-1:0] C_ANDI = 6'd16;
  localparam logic [CODE_BITS-1:0] C_SLLI = 6'd17;
  localparam logic [CODE_BITS-1:0] C_SRLI = 6'd18;
  localparam logic [CODE_BITS-1:0] C_SRAI = 6'd19;
  localparam logic [CODE_BITS-1:0] C_LB = 6'd20;
  localparam logic [CODE_BITS-1:0] C_LH = 6'd21;
  localparam logic [CODE_BITS-1:0] C_LW = 6'd22;
  localparam logic [CODE_BITS-1:0] C_LBU = 6'd23;
  localparam logic [CODE_BITS-1:0] C_LHU = 6'd24;
  localparam logic [CODE_BITS-1:0] C_SB = 6'd25;
  localparam logic [CODE_BITS-1:0] C_SH = 6'd26;
  localparam logic [CODE_BITS-1:0] C_SW = 6'd27;
  localparam logic [CODE_BITS-1:0] C_BEQ = 6'd28;
  localparam logic [CODE_BITS-1:0] C_BNE = 6'd29;
  localparam logic [CODE_BITS-1:0] C_BLT = 6'd30;
  localparam logic [CODE_BITS-1:0] C_BGE = 6'd31;
  localparam logic [CODE_BITS-1:0] C_BLTU = 6'd32;
  localparam logic [CODE_BITS-1:0] C_BGEU = 6'd33;
  localparam logic [CODE_BITS-1:0] C_JAL = 6'd34;
  localparam logic [CODE_BITS-1:0] C_JALR = 6'd35;
  localparam logic [CODE_BITS-1:0] C_LUI = 6'd36;
  localparam logic [CODE_BITS-1:0] C_AUIPC = 6'd37;
  localparam logic [CODE_BITS-1:0] C_MUL = 6'd38;
  localparam logic [CODE_BITS-1:0] C_MULH = 6'd39;
  localparam logic [CODE_BITS-1:0] C_MULHSU = 6'd40;
  localparam logic [CODE_BITS-1:0] C_MULHU = 6'd41;
  localparam logic [CODE_BITS-1:0] C_DIV = 6'd42;
  localparam logic [CODE_BITS-1:0] C_DIVU = 6'd43;
  localparam logic [CODE_BITS-1:0] C_REM = 6'd44;
  localparam logic [CODE_BITS-1:0] C_REMU = 6'd45;
  localparam logic [CODE_BITS-1:0] C_ILLEGAL = 6'h3f;
endpackage

// File: rtl/decode_stage_core.sv
// rv_decode_core: combinational RV32I/M field, immediate and instruction-code extraction
module rv_decode_core
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [ISIZE-1:0]     instr,
  output logic [CODE_BITS-1:0] code,
  output logic [ASIZE-1:0]     rs1,
  output logic [ASIZE-1:0]     rs2,
  output logic [ASIZE-1:0]     rd,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);
  logic [6:0] f7;
  logic [2:0] f3;
  logic [CODE_BITS-1:0] c;
  logic [XLEN-1:0] v, imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic u1, u2, ud;
  assign f7 = instr[31:25];
  assign f3 = instr[14:12];
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'h000}));
  assign imm_sh = XLEN'(instr[24:20]);
  always_comb begin
    c = C_ILLEGAL;
    v = '0;
    {u1, u2, ud} = 3'b000;
    case (instr[6:0])
      RTYPE_OPC: begin
        {u1, u2, ud} = 3'b111;
        if (f7 == 7'h01) c = ENABLE_M ? C_MUL + CODE_BITS'(f3) : C_ILLEGAL;
        else case ({f7, f3})
          {7'h00, 3'd0}: c = C_ADD;
          {7'h20, 3'd0}: c = C_SUB;
          {7'h00, 3'd1}: c = C_SLL;
          {7'h00, 3'd2}: c = C_SLT;
          {7'h00, 3'd3}: c = C_SLTU;
          {7'h00, 3'd4}: c = C_XOR;
          {7'h00, 3'd5}: c = C_SRL;
          {7'h20, 3'd5}: c = C_SRA;
          {7'h00, 3'd6}: c = C_OR;
          {7'h00, 3'd7}: c = C_AND;
          default: c = C_ILLEGAL;
        endcase
      end
      ITYPE_OPC: begin
        {u1, u2, ud} = 3'b101;
        v = (f3 == 3'd1 || f3 == 3'd5) ? imm_sh : imm_i;
        case (f3)
          3'd0: c = C_ADDI;
          3'd1: c = (f7 == 7'h00) ? C_SLLI : C_ILLEGAL;
          3'd2: c = C_SLTI;
          3'd3: c = C_SLTIU;
          3'd4: c = C_XORI;
          3'd5: c = (f7 == 7'h00) ? C_SRLI : (f7 == 7'h20) ? C_SRAI : C_ILLEGAL;
          3'd6: c = C_ORI;
          default: c = C_ANDI;
        endcase
      end
      LOAD_OPC: begin
        {u1, u2, ud} = 3'b101;
        v = imm_i;
        case (f3)
          3'd0: c = C_LB;
          3'd1: c = C_LH;
          3'd2: c = C_LW;
          3'd4: c = C_LBU;
          3'd5: c = C_LHU;
          default: c = C_ILLEGAL;
        endcase
      end
      STORE_OPC: begin
        {u1, u2, ud} = 3'b110;
        v = imm_s;
        c = (f3 == 3'd0) ? C_SB : (f3 == 3'd1) ? C_SH : (f3 == 3'd2) ? C_SW : C_ILLEGAL;
      end
      CONBRANCH_OPC: begin
        {u1, u2, ud} = 3'b110;
        v = imm_b;
        case (f3)
          3'd0: c = C_BEQ;
          3'd1: c = C_BNE;
          3'd4: c = C_BLT;
          3'd5: c = C_BGE;
          3'd6: c = C_BLTU;
          3'd7: c = C_BGEU;
          default: c = C_ILLEGAL;
        endcase
      end
      JAL_OPC: begin
        ud = 1'b1;
        v = imm_j;
        c = C_JAL;
      end
      JR_OPC: begin
        {u1, u2, ud} = 3'b101;
        v = imm_i;
        c = (f3 == 3'd0) ? C_JALR : C_ILLEGAL;
      end
      LUI_OPC, AUIPC_OPC: begin
        ud = 1'b1;
        v = imm_u;
        c = (instr[5]) ? C_LUI : C_AUIPC;
      end
      default: c = C_ILLEGAL;
    endcase
  end
  assign illegal = (c == C_ILLEGAL);
  assign code = c;
  assign rs1 = (u1 && !illegal) ? instr[19:15] : '0;
  assign rs2 = (u2 && !illegal) ? instr[24:20] : '0;
  assign rd = (ud && !illegal) ? instr[11:7] : '0;
  assign imm = illegal ? '0 : v;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with one-entry skid buffer, valid/ready handshake and flush
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int AW = 5,
  parameter int CODE_W = 6,
  parameter bit ENABLE_M = 1'b1,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CODE_W-1:0] out_code,
  output logic [AW-1:0]     out_rs1,
  output logic [AW-1:0]     out_rs2,
  output logic [AW-1:0]     out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal
);
  localparam int BW = PC_W + CODE_W + 3 * AW + XLEN + 1;
  logic [CODE_W-1:0] d_code;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm;
  logic d_ill, in_xfer, load_out;
  logic [BW-1:0] dec, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  rv_decode_core #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_core (
    .instr   (in_instr),
    .code    (d_code),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rd      (d_rd),
    .imm     (d_imm),
    .illegal (d_ill)
  );
  assign dec = {in_pc, d_code, d_rs1, d_rs2, d_rd, d_imm, d_ill};
  assign in_xfer = in_valid && in_ready_q;
  assign load_out = !out_valid_q || out_ready;
  always_comb begin
    out_valid_d = flush ? 1'b0 : load_out ? (skid_valid_q || in_xfer) : 1'b1;
    out_d = (flush || !load_out) ? out_q : skid_valid_q ? skid_q : in_xfer ? dec : out_q;
    skid_valid_d = (flush || load_out) ? 1'b0 : (skid_valid_q || in_xfer);
    skid_d = (!flush && !load_out && in_xfer) ? dec : skid_q;
    in_ready_d = !skid_valid_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      skid_valid_q <= 1'b0;
      skid_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign {out_pc, out_code, out_rs1, out_rs2, out_rd, out_imm, out_illegal} = out_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench with a queue/table reference model of decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} item_t;
  typedef struct {logic [5:0] code; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [31:0] imm; logic ill;} dec_t;
  typedef struct {logic [6:0] op; int f3; int f7; logic [5:0] code; byte fmt; bit m;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] pc = 32'h1000;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [5:0] out_code;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic nm_in_ready, nm_valid, nm_illegal;
  logic [31:0] nm_pc, nm_imm;
  logic [5:0] nm_code;
  logic [4:0] nm_rs1, nm_rs2, nm_rd;
  item_t q[$];
  ent_t tbl[$];
  logic rdy_m;
  dec_t e, en;
  int cmp_n = 0;
  int bad_n = 0;
  logic [31:0] vec [0:12] = '{32'h0042A303, 32'hFE112E23, 32'h123452B7, 32'h00001517, 32'h000080E7,
                             32'h000090E7, 32'h4030D093, 32'h02009093, 32'h00000000, 32'hFFFFFFFF,
                             32'h00000073, 32'h0020B1B3, 32'h0220D1B3};
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_code(out_code), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_illegal(out_illegal)
  );
  decode_stage #(.ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_valid), .out_ready(out_ready),
    .out_pc(nm_pc), .out_code(nm_code), .out_rs1(nm_rs1), .out_rs2(nm_rs2),
    .out_rd(nm_rd), .out_imm(nm_imm), .out_illegal(nm_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] b);
    cmp_n++;
    if (a !== b) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, b, $time);
    end
  endtask
  task automatic add_e(input logic [6:0] op, input int f3, input int f7, input logic [5:0] c, input byte fmt, input bit m);
    tbl.push_back('{op, f3, f7, c, fmt, m});
  endtask
  function automatic dec_t model(input logic [31:0] x, input bit m_en);
    dec_t d;
    int v;
    d = '{code: C_ILLEGAL, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, ill: 1'b1};
    if (x[1:0] == 2'b11)
      foreach (tbl[k])
        if (tbl[k].op == x[6:0] && (tbl[k].f3 < 0 || tbl[k].f3 == int'(x[14:12])) &&
            (tbl[k].f7 < 0 || tbl[k].f7 == int'(x[31:25])) && (m_en || !tbl[k].m)) begin
          d.code = tbl[k].code;
          d.ill = 1'b0;
          case (tbl[k].fmt)
            "R": begin d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.rd = x[11:7]; end
            "I": begin
              d.rs1 = x[19:15]; d.rd = x[11:7];
              v = int'(x[31:20]); if (v >= 2048) v -= 4096; d.imm = 32'(v);
            end
            "H": begin d.rs1 = x[19:15]; d.rd = x[11:7]; d.imm = 32'(x[24:20]); end
            "S": begin
              d.rs1 = x[19:15]; d.rs2 = x[24:20];
              v = int'({x[31:25], x[11:7]}); if (v >= 2048) v -= 4096; d.imm = 32'(v);
            end
            "B": begin
              d.rs1 = x[19:15]; d.rs2 = x[24:20];
              v = int'({x[31], x[7], x[30:25], x[11:8], 1'b0}); if (v >= 4096) v -= 8192; d.imm = 32'(v);
            end
            "J": begin
              d.rd = x[11:7];
              v = int'({x[31], x[19:12], x[20], x[30:21], 1'b0}); if (v >= 1048576) v -= 2097152; d.imm = 32'(v);
            end
            "U": begin d.rd = x[11:7]; d.imm = {x[31:12], 12'h000}; end
            default: ;
          endcase
        end
    return d;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      rdy_m <= 1'b0;
    end else if (flush) begin
      q.delete();
      rdy_m <= 1'b1;
    end else begin
      if (q.size() > 0 && out_ready) q.delete(0);
      if (in_valid && rdy_m) q.push_back('{instr: in_instr, pc: in_pc});
      rdy_m <= (q.size() < 2);
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(rdy_m));
      if (q.size() > 0) begin
        e = model(q[0].instr, 1'b1);
        en = model(q[0].instr, 1'b0);
        chk("pc", 64'(out_pc), 64'(q[0].pc));
        chk("code", 64'(out_code), 64'(e.code));
        chk("rs1", 64'(out_rs1), 64'(e.rs1));
        chk("rs2", 64'(out_rs2), 64'(e.rs2));
        chk("rd", 64'(out_rd), 64'(e.rd));
        chk("imm", 64'(out_imm), 64'(e.imm));
        chk("illegal", 64'(out_illegal), 64'(e.ill));
        chk("nm_code", 64'(nm_code), 64'(en.code));
        chk("nm_illegal", 64'(nm_illegal), 64'(en.ill));
      end
    end
  end
  task automatic send(input logic [31:0] i);
    int n = 0;
    in_valid = 1'b1;
    in_instr = i;
    in_pc = pc;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      bad_n++;
      $display("FAIL send_timeout: in_ready stuck low for instr %h", i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    pc += 4;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int k = 0; k < 8; k++) begin
      add_e(RTYPE_OPC, k, 1, C_MUL + 6'(k), "R", 1'b1);
    end
    add_e(RTYPE_OPC, 0, 0, C_ADD, "R", 0); add_e(RTYPE_OPC, 0, 32, C_SUB, "R", 0);
    add_e(RTYPE_OPC, 1, 0, C_SLL, "R", 0); add_e(RTYPE_OPC, 2, 0, C_SLT, "R", 0);
    add_e(RTYPE_OPC, 3, 0, C_SLTU, "R", 0); add_e(RTYPE_OPC, 4, 0, C_XOR, "R", 0);
    add_e(RTYPE_OPC, 5, 0, C_SRL, "R", 0); add_e(RTYPE_OPC, 5, 32, C_SRA, "R", 0);
    add_e(RTYPE_OPC, 6, 0, C_OR, "R", 0); add_e(RTYPE_OPC, 7, 0, C_AND, "R", 0);
    add_e(ITYPE_OPC, 0, -1, C_ADDI, "I", 0); add_e(ITYPE_OPC, 2, -1, C_SLTI, "I", 0);
    add_e(ITYPE_OPC, 3, -1, C_SLTIU, "I", 0); add_e(ITYPE_OPC, 4, -1, C_XORI, "I", 0);
    add_e(ITYPE_OPC, 6, -1, C_ORI, "I", 0); add_e(ITYPE_OPC, 7, -1, C_ANDI, "I", 0);
    add_e(ITYPE_OPC, 1, 0, C_SLLI, "H", 0); add_e(ITYPE_OPC, 5, 0, C_SRLI, "H", 0);
    add_e(ITYPE_OPC, 5, 32, C_SRAI, "H", 0);
    add_e(LOAD_OPC, 0, -1, C_LB, "I", 0); add_e(LOAD_OPC, 1, -1, C_LH, "I", 0);
    add_e(LOAD_OPC, 2, -1, C_LW, "I", 0); add_e(LOAD_OPC, 4, -1, C_LBU, "I", 0);
    add_e(LOAD_OPC, 5, -1, C_LHU, "I", 0);
    add_e(STORE_OPC, 0, -1, C_SB, "S", 0); add_e(STORE_OPC, 1, -1, C_SH, "S", 0);
    add_e(STORE_OPC, 2, -1, C_SW, "S", 0);
    add_e(CONBRANCH_OPC, 0, -1, C_BEQ, "B", 0); add_e(CONBRANCH_OPC, 1, -1, C_BNE, "B", 0);
    add_e(CONBRANCH_OPC, 4, -1, C_BLT, "B", 0); add_e(CONBRANCH_OPC, 5, -1, C_BGE, "B", 0);
    add_e(CONBRANCH_OPC, 6, -1, C_BLTU, "B", 0); add_e(CONBRANCH_OPC, 7, -1, C_BGEU, "B", 0);
    add_e(JAL_OPC, -1, -1, C_JAL, "J", 0); add_e(JR_OPC, 0, -1, C_JALR, "I", 0);
    add_e(LUI_OPC, -1, -1, C_LUI, "U", 0); add_e(AUIPC_OPC, -1, -1, C_AUIPC, "U", 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_code", 64'(out_code), 64'd0);
    chk("rst_fields", 64'({out_rs1, out_rs2, out_rd, out_illegal}), 64'd0);
    chk("rst_imm_pc", {out_imm, out_pc}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    send(32'h002081B3);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_code", 64'(out_code), 64'd1);
    chk("add_regs", 64'({out_rs1, out_rs2, out_rd}), 64'({5'd1, 5'd2, 5'd3}));
    chk("add_imm_ill", 64'({out_imm, out_illegal}), 64'd0);
    send(32'h402081B3);
    chk("sub_code", 64'(out_code), 64'd2);
    chk("sub_rd", 64'(out_rd), 64'd3);
    send(32'hFFF00293);
    chk("addi_no_bubble", 64'(out_valid), 64'd1);
    chk("addi_code_rd", 64'({out_code, out_rd}), 64'({6'd11, 5'd5}));
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    send(32'hFE209EE3);
    chk("bne_code", 64'(out_code), 64'd29);
    chk("bne_imm", 64'(out_imm), 64'hFFFFFFFC);
    send(32'h008000EF);
    chk("jal_code_rd", 64'({out_code, out_rd}), 64'({6'd34, 5'd1}));
    chk("jal_imm", 64'(out_imm), 64'h8);
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h00310233);
    send(32'h0062F3B3);
    chk("skid_full_ready", 64'(in_ready), 64'd0);
    fork
      send(32'h00A4C533);
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    send(32'h022081B3);
    chk("mul_code", 64'(out_code), 64'd38);
    chk("nm_mul_illegal", 64'({nm_illegal, nm_code}), 64'({1'b1, 6'h3F}));
    for (int k = 0; k < 13; k++) begin
      out_ready = (k % 3 != 2);
      send(vec[k]);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    send(32'h00208133);
    send(32'h40208133);
    chk("pre_flush_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drops_input", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("flush_stays_empty", 64'(out_valid), 64'd0);
    send(32'h00208133);
    send(32'h0042A303);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_code", 64'(out_code), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(32'h002081B3);
    send(32'hFE209EE3);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage between fetch and execute.
- Decodes the RV32I base integer set plus optional M-extension multiply into rs1/rs2/rd, a sign-extended immediate, an instruction code and an illegal flag.
- Holds results in an output register backed by a one-entry skid buffer, so back-pressure never drops an instruction and throughput stays at one per cycle.
- Supports pipeline flush from branch resolution.

Parameters:
- XLEN, 32, datapath/immediate width (`DSIZE in define.v).
- ILEN, 32, instruction width (`ISIZE).
- AW, 5, register address width (`ASIZE).
- CODE_W, 6, instr_code width.
- ENABLE_M, 1, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = flag them illegal.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  ILEN  raw instruction.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  PC_W  passed-through PC.
- out_code  out  CODE_W  instruction code (define.v constants).
- out_rs1  out  AW  source register 1.
- out_rs2  out  AW  source register 2.
- out_rd  out  AW  destination register.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, skid empty.
  - All out_* fields 0; out_code=`NOP (0).
  - in_ready=1 on the first edge after release.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency: 1 cycle from input transfer to out_valid.
- in_ready is registered and equals !skid_full.
- Storage cases:
  - Output register empty, or draining this cycle: the new decode loads the output register.
  - Output register full and stalled: the new decode loads the skid entry, and in_ready drops next cycle.
  - Skid entry full and output drains: skid moves into the output register, and in_ready returns 1.
  - Simultaneous input and output transfers with skid empty: the output register is replaced; no bubble.
- Stability: fields stay stable while out_valid & !out_ready.
- flush:
  - Next cycle out_valid=0 and skid empty.
  - A same-cycle input transfer is dropped.
  - Flush has priority over every other event.
  - in_ready=1 after a flush.
- Decode, combinational, inside the core:
  - Fields not used by a format are driven 0, never latched.
  - R-type: rs1, rs2, rd. funct7/funct3 select ADD SUB SLL SLT SLTU XOR SRL SRA OR AND, plus M ops when ENABLE_M.
  - I-ALU: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI. imm = sext(instr[31:20]). For shifts, imm = zero-extended shamt instr[24:20]; funct7 must be 0000000 or 0100000 (SRAI).
  - Loads: LB LH LW LBU LHU.
  - Stores: SB SH SW. imm = sext({instr[31:25],instr[11:7]}).
  - Branches: BEQ BNE BLT BGE BLTU BGEU. imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - JAL: imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - JALR (JR_OPC): imm = sext(instr[31:20]), funct3 must be 000.
  - LUI / AUIPC: imm = {instr[31:12],12'b0}.
- Illegal instructions:
  - Trigger: any unlisted opcode, funct3 or funct7; M ops when ENABLE_M=0; instr[1:0]!=2'b11.
  - Result: out_illegal=1, out_code=`ILLEGAL, register fields 0.
  - The instruction still flows as valid so execute can trap.
- Sign extension is always from the format's top bit to XLEN.

Decomposition:
- define.v (shared) holds:
  - All opcode constants (RTYPE_OPC … CONBRANCH_OPC, plus LUI_OPC, AUIPC_OPC).
  - The instruction-code constants, widened to CODE_W, with NOP=0 and ILLEGAL = all ones.
  - ISIZE/ASIZE/DSIZE.
- Sub-module rv_decode_core: purely combinational field/immediate/code extraction, parameterised by XLEN, ENABLE_M.
- decode_stage wraps rv_decode_core with the output register, skid and handshake.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, code=`ADD, rs1=1, rs2=2, rd=3, imm=0, illegal=0.
- SUB 0x402081B3, then ADDI x5,x0,-1 (0xFFF00293) back-to-back:
  - Sequential outputs SUB rd=3, then ADDI rd=5, imm=0xFFFFFFFF.
  - No bubble.
- BNE x1,x2,-4 (0xFE209EE3) → code=`BNE, imm=0xFFFFFFFC. JAL x1,+8 (0x008000EF) → code=`JAL, rd=1, imm=0x00000008.
- Hold out_ready=0, then send three instructions:
  - First held in the output register, second in skid.
  - in_ready=0 from the cycle after the second transfer.
  - Raise out_ready → outputs appear in order, nothing lost or duplicated.
- ENABLE_M=0, MUL 0x022081B3 → out_illegal=1, code=`ILLEGAL. ENABLE_M=1, same instruction → code=`MUL.
- Skid full, assert flush together with in_valid → next cycle out_valid=0, in_ready=1. Deassert rst_n mid-stall → out_valid=0 immediately (async).
